// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the bus DMA initiator
// Purpose: FSM state encoding and address constants used by bus_dma_initiator.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam logic [31:0] WORD_BYTES      = 32'd4;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/bus_dma_initiator.sv
// rtl/bus_dma_initiator.sv - word-copy DMA initiator for the simple peripheral bus
// Purpose: copies len_words words from src_addr to dst_addr, one read beat then
// one write beat per word, stalling whenever the arbiter withholds m_gnt.
// Optional feature macro: DMA_IRQ_EN (sticky completion interrupt on irq).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, abort          begin a transfer (IDLE only) / cancel it (RD, WR only)
//   src_addr, dst_addr    byte addresses, bits [1:0] ignored
//   len_words             number of words to copy
//   m_valid, m_gnt        bus request / arbiter grant
//   m_addr, m_we, m_wdata bus address, write strobe, write data
//   m_rdata               combinational read data for m_addr
//   busy, done            transfer active / one-cycle completion pulse
//   irq, irq_clr          sticky completion interrupt and its clear
module bus_dma_initiator
  import dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             m_valid,
  input  logic             m_gnt,
  output logic [31:0]      m_addr,
  output logic             m_we,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata,
  output logic             busy,
  output logic             done,
  output logic             irq,
  input  logic             irq_clr
);

  localparam logic [LEN_W-1:0] COUNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e           r_state, w_state_n;
  logic [31:0]      r_src, w_src_n;
  logic [31:0]      r_dst, w_dst_n;
  logic [LEN_W-1:0] r_count, w_count_n;
  logic [31:0]      r_buf, w_buf_n;

  logic             r_m_valid, w_m_valid_n;
  logic             r_m_we, w_m_we_n;
  logic [31:0]      r_m_addr, w_m_addr_n;
  logic [31:0]      r_m_wdata, w_m_wdata_n;
  logic             r_busy, w_busy_n;
  logic             r_done, w_done_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next state and next outputs are computed together so that every bus
  // output is a register that lines up with the state it belongs to.
  always_comb begin
    w_state_n   = r_state;
    w_src_n     = r_src;
    w_dst_n     = r_dst;
    w_count_n   = r_count;
    w_buf_n     = r_buf;
    w_m_valid_n = 1'b0;
    w_m_we_n    = 1'b0;
    w_m_addr_n  = r_m_addr;
    w_m_wdata_n = r_m_wdata;
    w_done_n    = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          if (len_words != '0) begin
            w_src_n     = src_addr & ADDR_ALIGN_MASK;
            w_dst_n     = dst_addr & ADDR_ALIGN_MASK;
            w_count_n   = len_words;
            w_state_n   = RD;
            w_m_valid_n = 1'b1;
            w_m_addr_n  = src_addr & ADDR_ALIGN_MASK;
          end else begin
            w_state_n = DONE;
            w_done_n  = 1'b1;
          end
        end
      end
      RD: begin
        // abort outranks the grant: the beat in flight never completes
        if (abort) begin
          w_state_n = IDLE;
        end else if (m_gnt) begin
          w_buf_n     = m_rdata;
          w_state_n   = WR;
          w_m_valid_n = 1'b1;
          w_m_we_n    = 1'b1;
          w_m_addr_n  = r_dst;
          w_m_wdata_n = m_rdata;
        end else begin
          w_m_valid_n = 1'b1;
        end
      end
      WR: begin
        if (abort) begin
          w_state_n = IDLE;
        end else if (m_gnt) begin
          w_src_n   = r_src + WORD_BYTES;
          w_dst_n   = r_dst + WORD_BYTES;
          w_count_n = r_count - COUNT_ONE;
          if (r_count == COUNT_ONE) begin
            w_state_n = DONE;
            w_done_n  = 1'b1;
          end else begin
            w_state_n   = RD;
            w_m_valid_n = 1'b1;
            w_m_addr_n  = r_src + WORD_BYTES;
          end
        end else begin
          w_m_valid_n = 1'b1;
          w_m_we_n    = 1'b1;
          w_m_wdata_n = r_buf;
        end
      end
      DONE: begin
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase

    w_busy_n = (w_state_n == RD) || (w_state_n == WR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_count   <= '0;
      r_buf     <= '0;
      r_m_valid <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_src     <= w_src_n;
      r_dst     <= w_dst_n;
      r_count   <= w_count_n;
      r_buf     <= w_buf_n;
      r_m_valid <= w_m_valid_n;
      r_m_we    <= w_m_we_n;
      r_m_addr  <= w_m_addr_n;
      r_m_wdata <= w_m_wdata_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
    end
  end

  assign m_valid = r_m_valid;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign busy    = r_busy;
  assign done    = r_done;

`ifdef DMA_IRQ_EN
  logic r_irq;

  // Set from the registered done pulse, so a clear in the done cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else if (irq_clr) begin
      r_irq <= 1'b0;
    end else if (r_done) begin
      r_irq <= 1'b1;
    end
  end

  assign irq = r_irq;
`else
  logic w_unused_irq_clr;

  assign w_unused_irq_clr = irq_clr;
  assign irq              = 1'b0;
`endif

endmodule

// File: tb/tb_bus_dma_initiator.sv
// tb/tb_bus_dma_initiator.sv - self-checking bench for bus_dma_initiator
module tb_bus_dma_initiator;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len_words;
  logic             m_valid;
  logic             m_gnt;
  logic [31:0]      m_addr;
  logic             m_we;
  logic [31:0]      m_wdata;
  logic [31:0]      m_rdata;
  logic             busy;
  logic             done;
  logic             irq;
  logic             irq_clr;

  bus_dma_initiator #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len_words (len_words),
    .m_valid   (m_valid),
    .m_gnt     (m_gnt),
    .m_addr    (m_addr),
    .m_we      (m_we),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .busy      (busy),
    .done      (done),
    .irq       (irq),
    .irq_clr   (irq_clr)
  );

  always #5 clk = ~clk;

  // Source memory: 0xA,0xB,0xC at 0x100..0x108, an address hash elsewhere.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a >= 32'h100 && a <= 32'h108) return 32'hA + ((a - 32'h100) >> 2);
    return a ^ 32'hA5C3_0F1E;
  endfunction

  assign m_rdata = mem_rd(m_addr);

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t got[$];

  // A beat completes at the coming edge when requested, granted, not aborted.
  always @(negedge clk) begin
    if (!reset && m_valid && m_gnt && !abort)
      got.push_back('{m_we, m_addr, (m_we ? m_wdata : m_rdata)});
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one transfer from the start pulse through one cycle after done,
  // comparing the observed bus beats with the word-copy model.
  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst,
                          input logic [LEN_W-1:0] len, input logic [31:0] stall_at,
                          input int stall_n, input bit rand_gnt, input bit start_mid,
                          input bit clr_on_done, output int cyc, output int busy_cyc);
    beat_t expq[$];
    bit    got_done = 0;
    bit    valid_seen = 0;
    bit    stalled = 0;
    int    stall_left = 0;
    logic  exp_irq;
    got.delete();
    @(posedge clk); #1;
    start = 1; src_addr = src; dst_addr = dst; len_words = len; m_gnt = 1; irq_clr = 1;
    @(posedge clk); #1;
    start = 0; irq_clr = 0;
    src_addr = $urandom; dst_addr = $urandom; len_words = LEN_W'($urandom);
    busy_cyc = 0;
    cyc = 0;
    for (int c = 1; c <= 400; c++) begin
      cyc = c;
      m_gnt = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stall_left > 0) begin
        m_gnt = 0;
        stall_left--;
        check("stall_addr_hold", m_addr, stall_at);
        check("stall_valid_hold", m_valid, 1);
      end else if (stall_n > 0 && !stalled && m_valid && !m_we && m_addr == stall_at) begin
        stalled = 1;
        m_gnt = 0;
        stall_left = stall_n - 1;
      end
      start = start_mid && (c == 2);
      if (start) begin
        src_addr = 32'h900; dst_addr = 32'hA00; len_words = 7;
      end
      if (m_valid) valid_seen = 1;
      if (busy) busy_cyc++;
      if (done) begin
        got_done = 1;
        irq_clr = clr_on_done;
        break;
      end
      @(posedge clk); #1;
    end
    start = 0; m_gnt = 1;
    check("done_seen", got_done, 1);
    check("valid_seen", valid_seen, (len != 0));
    for (int i = 0; i < int'(len); i++) begin
      logic [31:0] ra;
      logic [31:0] wa;
      ra = (src & 32'hFFFF_FFFC) + 32'(4 * i);
      wa = (dst & 32'hFFFF_FFFC) + 32'(4 * i);
      expq.push_back('{1'b0, ra, mem_rd(ra)});
      expq.push_back('{1'b1, wa, mem_rd(ra)});
    end
    check("beat_count", got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      check("beat_we", got[i].we, expq[i].we);
      check("beat_addr", got[i].addr, expq[i].addr);
      check("beat_data", got[i].data, expq[i].data);
    end
    @(posedge clk); #1;
    irq_clr = 0;
    check("done_one_cycle", done, 0);
    check("idle_after_done", {busy, m_valid, m_we}, 0);
`ifdef DMA_IRQ_EN
    exp_irq = got_done && !clr_on_done;
`else
    exp_irq = 1'b0;
`endif
    check("irq_after_done", irq, exp_irq);
  endtask

  typedef struct {
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic [31:0]      stall_at;
    int               stall_n;
    bit               start_mid;
    int               exp_cyc;
    int               exp_busy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc;
    int bcyc;
    bit seen;
    reset = 1; start = 0; abort = 0; m_gnt = 0; irq_clr = 0;
    src_addr = 0; dst_addr = 0; len_words = 0;

    vecs[0] = '{32'h100,      32'h200, 16'd3, 32'h0,   0, 1'b0,  7, 6};
    vecs[1] = '{32'h100,      32'h200, 16'd3, 32'h104, 3, 1'b0, 10, 9};
    vecs[2] = '{32'h100,      32'h200, 16'd0, 32'h0,   0, 1'b0,  1, 0};
    vecs[3] = '{32'hFFFF_FFFE, 32'h300, 16'd2, 32'h0,   0, 1'b0,  5, 4};
    vecs[4] = '{32'h100,      32'h200, 16'd3, 32'h0,   0, 1'b1,  7, 6};
    vecs[5] = '{32'h1003,     32'h2001, 16'd1, 32'h0,  0, 1'b0,  3, 2};

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", m_valid, 0);
    check("reset_we", m_we, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_irq", irq, 0);
    check("reset_addr", m_addr, 0);
    check("reset_wdata", m_wdata, 0);
    reset = 0;

    foreach (vecs[i]) begin
      run_xfer(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].stall_at,
               vecs[i].stall_n, 1'b0, vecs[i].start_mid, 1'b0, cyc, bcyc);
      check($sformatf("vec%0d_done_cycle", i), cyc, vecs[i].exp_cyc);
      check($sformatf("vec%0d_busy_cycles", i), bcyc, vecs[i].exp_busy);
    end

    for (int i = 0; i < 15; i++) begin
      run_xfer($urandom, $urandom, LEN_W'($urandom_range(1, 6)), 32'h0, 0,
               1'b1, 1'b0, 1'b0, cyc, bcyc);
    end

    // Abort during the write of word 2 of 4.
    got.delete();
    @(posedge clk); #1;
    start = 1; src_addr = 32'h400; dst_addr = 32'h800; len_words = 4; m_gnt = 1;
    @(posedge clk); #1;
    start = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_we && m_addr == 32'h804) break;
      @(posedge clk); #1;
    end
    check("abort_reach_wr2", {m_we, m_addr}, {1'b1, 32'h804});
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    check("abort_idle", {busy, m_valid, m_we, done}, 0);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    check("abort_no_done", seen, 0);
    check("abort_beats", got.size(), 3);
    seen = 0;
    foreach (got[i]) if (got[i].we && got[i].addr == 32'h804) seen = 1;
    check("abort_no_dst4_write", seen, 0);

    // Reset while in RD.
    @(posedge clk); #1;
    start = 1; src_addr = 32'h500; dst_addr = 32'h600; len_words = 4;
    @(posedge clk); #1;
    start = 0;
    check("pre_reset_rd", {m_valid, m_we}, 2'b10);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("rst_mid_outputs", {m_valid, m_we, busy, done, irq}, 0);
    check("rst_mid_addr", m_addr, 0);
    check("rst_mid_wdata", m_wdata, 0);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    check("rst_mid_no_done", seen, 0);

    // Sticky interrupt, then clear coincident with done.
    run_xfer(32'h100, 32'h200, 16'd1, 32'h0, 0, 1'b0, 1'b0, 1'b0, cyc, bcyc);
    repeat (3) @(posedge clk);
    #1;
`ifdef DMA_IRQ_EN
    check("irq_sticky", irq, 1);
`else
    check("irq_tied_low", irq, 0);
`endif
    irq_clr = 1;
    @(posedge clk); #1;
    irq_clr = 0;
    check("irq_cleared", irq, 0);
    run_xfer(32'h100, 32'h200, 16'd2, 32'h0, 0, 1'b0, 1'b0, 1'b1, cyc, bcyc);
    repeat (2) @(posedge clk);
    #1;
    check("irq_clr_on_done", irq, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
